// File: rtl/swervolf_uart_sel.sv
// rtl/swervolf_uart_sel.sv - glitch-free N-way UART TX selector that switches only between frames
module swervolf_uart_sel #(
  parameter int CHANNELS    = 2,
  parameter int SEL_W       = 1,
  parameter int IDLE_CYCLES = 4340,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [SEL_W-1:0]    i_sel,
  input  logic [CHANNELS-1:0] i_tx,
  output logic                o_tx,
  output logic [SEL_W-1:0]    o_active,
  output logic                o_switching
);

  localparam int               CNT_W    = $clog2(IDLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(IDLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [SEL_W:0]   SEL_LIM  = (SEL_W + 1)'(CHANNELS);

  typedef enum logic [1:0] {RUN, DRAIN, QUIET} state_t;

  logic [SYNC_STAGES-1:0][SEL_W-1:0]    sel_sync;
  logic [SYNC_STAGES-1:0][CHANNELS-1:0] tx_sync;
  logic [SEL_W-1:0]                     sel_s;
  logic [CHANNELS-1:0]                  tx_s;

  // Idle-high reset on the TX synchronisers keeps o_tx quiet while they refill.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sel_sync <= '0;
      tx_sync  <= '1;
    end else begin
      sel_sync <= {sel_sync[SYNC_STAGES-2:0], i_sel};
      tx_sync  <= {tx_sync[SYNC_STAGES-2:0], i_tx};
    end
  end

  assign sel_s = sel_sync[SYNC_STAGES-1];
  assign tx_s  = tx_sync[SYNC_STAGES-1];

  state_t              state, state_n;
  logic [SEL_W-1:0]    target, target_n;
  logic [SEL_W-1:0]    active_n;
  logic [CNT_W-1:0]    cnt, cnt_n, cnt_step;
  logic                tx_n;
  logic [2**SEL_W-1:0] tx_pad;
  logic                line;
  logic                sel_ok;
  logic                req;
  logic                cnt_done;

  // Unused select codes read as an idle line so the index is always in range.
  always_comb begin
    tx_pad                 = '1;
    tx_pad[CHANNELS-1:0]   = tx_s;
  end

  assign line     = tx_pad[o_active];
  assign sel_ok   = {1'b0, sel_s} < SEL_LIM;
  assign req      = sel_ok && (sel_s != o_active);
  assign cnt_done = line && (cnt == CNT_LAST);
  assign cnt_step = !line ? '0 : ((cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= RUN;
      o_active <= '0;
      target   <= '0;
      cnt      <= '0;
      o_tx     <= 1'b1;
    end else begin
      state    <= state_n;
      o_active <= active_n;
      target   <= target_n;
      cnt      <= cnt_n;
      o_tx     <= tx_n;
    end
  end

  always_comb begin
    state_n  = state;
    active_n = o_active;
    target_n = target;
    cnt_n    = cnt;
    tx_n     = o_tx;
    case (state)
      RUN: begin
        tx_n = line;
        if (req) begin
          target_n = sel_s;
          cnt_n    = '0;
          state_n  = DRAIN;
        end
      end
      DRAIN: begin
        tx_n  = line;
        cnt_n = cnt_step;
        if (sel_s == o_active) begin
          cnt_n   = '0;
          state_n = RUN;
        end else begin
          if (req) target_n = sel_s;
          // The old line has been idle long enough: hand over, but keep the output masked.
          if (cnt_done) begin
            active_n = req ? sel_s : target;
            cnt_n    = '0;
            state_n  = QUIET;
          end
        end
      end
      QUIET: begin
        tx_n  = 1'b1;
        cnt_n = cnt_step;
        if (req) begin
          active_n = sel_s;
          cnt_n    = '0;
        end else if (cnt_done) begin
          state_n = RUN;
        end
      end
      default: begin
        tx_n    = 1'b1;
        cnt_n   = '0;
        state_n = RUN;
      end
    endcase
  end

  assign o_switching = (state != RUN);

endmodule

// File: doc/swervolf_uart_sel.md
Name: swervolf_uart_sel

Overview:
Parametrised, glitch-free N-way UART TX selector for the board toplevels. It replaces the plain switch-driven combinational mux between the CPU and the LiteDRAM debug UART. The active source changes only at frame boundaries: the outgoing channel must go quiet, then the incoming channel must be idle, so the host terminal never receives a truncated or spliced character. All inputs may be asynchronous to clk (switches and UARTs from other clock domains); they are synchronised internally.

Parameters:
CHANNELS, 2, number of TX sources (2..16)
SEL_W, 1, width of i_sel; must satisfy 2**SEL_W >= CHANNELS
IDLE_CYCLES, 4340, consecutive high cycles that count as line idle (10 bit times; 50 MHz, 115200 baud)
SYNC_STAGES, 2, synchroniser depth for i_sel and i_tx (>=2)

Ports:
clk  input  1  core clock
rstn  input  1  asynchronous active-low reset
i_sel  input  SEL_W  requested channel index (switch input, asynchronous)
i_tx  input  CHANNELS  TX lines, bit n = channel n, idle high, asynchronous
o_tx  output  1  selected TX line to the board pin, registered
o_active  output  SEL_W  channel currently routed to o_tx
o_switching  output  1  high while a channel change is in progress

Behaviour:
- Reset (async on rstn low, all state):
  - o_tx=1, o_active=0, o_switching=0, state=RUN, counter=0.
  - i_sel synchroniser flops reset to 0; i_tx synchroniser flops reset to 1.
  - Reset mid-switch abandons the switch; channel 0 is active after reset.
- Synchronisation: sel_s and tx_s are i_sel and i_tx after SYNC_STAGES flops.
- o_tx is registered, giving SYNC_STAGES+1 cycles latency from i_tx[active] to o_tx.
- A request is valid when sel_s != o_active and sel_s < CHANNELS.
- Out-of-range sel_s (>= CHANNELS) is ignored everywhere; it behaves as "no change".
- Counter width is clog2(IDLE_CYCLES+1) and saturates at IDLE_CYCLES.
- State RUN:
  - o_tx <= tx_s[o_active]; o_switching=0.
  - On a valid request: target <= sel_s, counter <= 0, go to DRAIN.
- State DRAIN (old channel still routed):
  - o_tx <= tx_s[o_active]; o_switching=1.
  - Counter increments while tx_s[o_active]=1 and clears to 0 whenever it is 0.
  - sel_s == o_active: return to RUN (cancel); o_tx is never interrupted.
  - sel_s a different valid channel: target <= sel_s; counter is not cleared.
  - Counter reaches IDLE_CYCLES-1 with line high: o_active <= target, counter <= 0, go to QUIET.
  - If the old channel is held low (break), DRAIN waits indefinitely. This is intentional: breaks are never cut.
- State QUIET (new channel routed but masked):
  - o_tx <= 1; o_switching=1.
  - Counter counts consecutive high cycles of tx_s[o_active] and clears on low.
  - A valid request (sel_s != o_active): o_active <= sel_s, counter <= 0, stay in QUIET.
  - Counter reaches IDLE_CYCLES-1 with line high: go to RUN.
  - The first RUN cycle drives tx_s[o_active], so the output never starts mid-frame.
- Simultaneous events:
  - A request change arriving on the same cycle as counter completion uses the value sampled that cycle.
  - In DRAIN, target updates and the transition to QUIET both happen, using the new sel_s.
- o_active changes only on the DRAIN→QUIET edge or on a QUIET retarget, never in RUN.
- o_tx is glitch-free: it is driven from a single flop, with no combinational path from i_sel.

Test Plan:
Bench configuration: CHANNELS=3, SEL_W=2, IDLE_CYCLES=20, SYNC_STAGES=2.

1. Reset/latency: rstn low then high, i_tx=3'b111, i_sel=0, pulse i_tx[0] low for 5 cycles.
   - During reset: o_tx=1, o_active=0, o_switching=0.
   - o_tx goes low 3 cycles after i_tx[0] falls and stays low 5 cycles.
2. Clean switch: channel 0 sending a frame, set i_sel=1 mid-frame.
   - The frame completes unbroken on o_tx.
   - After 20 idle cycles o_active=1 and o_tx is held 1.
   - After channel 1 has been idle for 20 cycles, o_switching falls and channel 1 bits appear 3 cycles later.
3. Cancel: i_sel=1 then back to 0 during DRAIN.
   - o_switching returns to 0, o_active stays 0, o_tx unaffected.
4. Busy incoming channel: switch 0→2 while channel 2 toggles with gaps under 20 cycles.
   - Stays in QUIET with o_tx=1 until a 20-cycle high gap on channel 2, then RUN.
5. Invalid/retarget:
   - i_sel=3: no state change, o_switching stays 0.
   - In QUIET targeting 1, set i_sel=2: o_active=2, counter restarts, RUN after 20 idle cycles of channel 2.
6. Async reset mid-DRAIN, with channel 0 held low: o_tx=1, o_active=0, state RUN, immediately on rstn fall.
